// File: rtl/zwait_svc.sv
// Z80 wait-state service: resynchronises wait requests, raises a level request to the AVR,
// and issues a glitch-free wait_end release pulse on command, on timeout, or on guard retry.
module zwait_svc #(
    parameter int unsigned END_LEN = 4,
    parameter logic [15:0] TMO     = 16'd50000
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic [6:0] waits,
    input  logic       rd_stb,
    input  logic       wr_stb,
    input  logic [7:0] wr_data,
    output logic [7:0] status,
    output logic       wait_end,
    output logic       wait_int,
    output logic       tmo_err
);

    // state | meaning
    // IDLE  | no wait request outstanding, watching wsync
    // PEND  | request latched, wait_int high, timeout counter running
    // REL   | wait_end high for END_LEN cycles
    // GUARD | wait_end low, waiting for the flags to clear (retry after 8 cycles)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        REL   = 2'd2,
        GUARD = 2'd3
    } state_t;

    localparam logic [3:0]  END_LAST   = 4'(END_LEN - 1);
    localparam logic [3:0]  GUARD_LAST = 4'd7;
    localparam logic [15:0] TMO_LAST   = TMO - 16'd1;

    state_t      state;
    logic [6:0]  sync1;
    logic [6:0]  wsync;
    logic [6:0]  reason;
    logic [15:0] tmo_cnt;
    logic [3:0]  end_cnt;
    logic        rel_cmd;
    logic        clr_cmd;

    assign rel_cmd = wr_stb && wr_data[0];
    assign clr_cmd = wr_stb && wr_data[1];
    assign status  = {wait_int, reason};

    // Status reads are side-effect free; upper command bits are reserved.
    logic unused_inputs;
    assign unused_inputs = ^{rd_stb, wr_data[7:2]};

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sync1    <= '0;
            wsync    <= '0;
            reason   <= '0;
            tmo_cnt  <= '0;
            end_cnt  <= '0;
            wait_end <= 1'b0;
            wait_int <= 1'b0;
            tmo_err  <= 1'b0;
        end else begin
            sync1 <= waits;
            wsync <= sync1;

            // A timeout set later in this block overrides the clear.
            if (clr_cmd)
                tmo_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (wsync != 7'd0) begin
                        reason   <= wsync;
                        tmo_cnt  <= '0;
                        wait_int <= 1'b1;
                        state    <= PEND;
                    end
                end
                PEND: begin
                    reason <= reason | wsync;
                    if (rel_cmd) begin
                        wait_int <= 1'b0;
                        wait_end <= 1'b1;
                        end_cnt  <= '0;
                        state    <= REL;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_err  <= 1'b1;
                        wait_int <= 1'b0;
                        wait_end <= 1'b1;
                        end_cnt  <= '0;
                        state    <= REL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                REL: begin
                    if (end_cnt == END_LAST) begin
                        wait_end <= 1'b0;
                        end_cnt  <= '0;
                        state    <= GUARD;
                    end else begin
                        end_cnt <= end_cnt + 4'd1;
                    end
                end
                GUARD: begin
                    if (wsync == 7'd0) begin
                        end_cnt <= '0;
                        state   <= IDLE;
                    end else if (end_cnt == GUARD_LAST) begin
                        wait_end <= 1'b1;
                        end_cnt  <= '0;
                        state    <= REL;
                    end else begin
                        end_cnt <= end_cnt + 4'd1;
                    end
                end
                default: begin
                    wait_end <= 1'b0;
                    wait_int <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zwait_svc.sv
// Self-checking bench for zwait_svc with a wait-generator model that clears the flags on wait_end.
module tb_zwait_svc;

    localparam int          END_LEN = 4;
    localparam logic [15:0] TMO     = 16'd100;

    logic       fclk;
    logic       rst_n;
    logic [6:0] waits;
    logic       rd_stb;
    logic       wr_stb;
    logic [7:0] wr_data;
    logic [7:0] status;
    logic       wait_end;
    logic       wait_int;
    logic       tmo_err;

    logic stuck;
    int   n_checks;
    int   n_fails;
    int   len;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    zwait_svc #(.END_LEN(END_LEN), .TMO(TMO)) dut (
        .fclk    (fclk),
        .rst_n   (rst_n),
        .waits   (waits),
        .rd_stb  (rd_stb),
        .wr_stb  (wr_stb),
        .wr_data (wr_data),
        .status  (status),
        .wait_end(wait_end),
        .wait_int(wait_int),
        .tmo_err (tmo_err)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            chk(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    // Wait-generator model: its flip-flops are cleared while wait_end is high.
    task automatic tick();
        @(posedge fclk);
        #1;
        if (wait_end && !stuck)
            waits = 7'd0;
    endtask

    task automatic cmd(input logic [7:0] d);
        wr_data = d;
        wr_stb  = 1'b1;
        tick();
        wr_stb  = 1'b0;
        wr_data = 8'h00;
    endtask

    task automatic wait_for_int();
        int n;
        n = 0;
        while (!wait_int && n < 20) begin
            tick();
            n++;
        end
        chk("wait_int_timeout", {31'd0, wait_int}, 32'd1);
        sb_pop({24'd0, status});
    endtask

    task automatic wait_pulse();
        int n;
        n = 0;
        while (!wait_end && n < 40) begin
            tick();
            n++;
        end
        len = 0;
        while (wait_end && len < 40) begin
            len++;
            tick();
        end
        sb_pop(len);
    endtask

    task automatic no_pulse(input string tag, input int cycles);
        int highs;
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            if (wait_end) highs++;
            tick();
        end
        chk(tag, highs, 0);
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fails  = 0;
        stuck    = 1'b0;
        rst_n    = 1'b0;
        waits    = 7'd0;
        rd_stb   = 1'b0;
        wr_stb   = 1'b0;
        wr_data  = 8'h00;

        repeat (3) tick();
        chk("rst_status", status, 8'h00);
        chk("rst_wait_end", wait_end, 1'b0);
        chk("rst_wait_int", wait_int, 1'b0);
        chk("rst_tmo_err", tmo_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // Basic request / release, third-edge latency
        waits = 7'h01;
        sb_push("pend_status_81", 8'h81);
        tick();
        tick();
        chk("pend_not_before_3rd", wait_int, 1'b0);
        tick();
        chk("pend_on_3rd", wait_int, 1'b1);
        wait_for_int();
        rd_stb = 1'b1;
        tick();
        rd_stb = 1'b0;
        chk("rd_no_side_effect", {wait_int, status}, {1'b1, 8'h81});
        sb_push("release_pulse", END_LEN);
        cmd(8'h01);
        chk("rel_wait_end", wait_end, 1'b1);
        wait_pulse();
        tick();
        chk("idle_status_01", status, 8'h01);
        chk("idle_wait_int", wait_int, 1'b0);
        no_pulse("single_pulse", 20);

        // Timeout
        waits = 7'h02;
        sb_push("pend_status_82", 8'h82);
        wait_for_int();
        n = 0;
        while (wait_int && n < 200) begin
            n++;
            tick();
        end
        chk("tmo_pend_cycles", n, TMO);
        chk("tmo_err_set", tmo_err, 1'b1);
        sb_push("tmo_pulse", END_LEN);
        wait_pulse();
        tick();
        chk("tmo_err_sticky", tmo_err, 1'b1);
        cmd(8'h02);
        chk("tmo_err_cleared", tmo_err, 1'b0);
        cmd(8'h01);
        no_pulse("rel_outside_pend", 10);

        // Release coincident with last timeout cycle
        waits = 7'h04;
        sb_push("pend_status_84", 8'h84);
        wait_for_int();
        repeat (int'(TMO) - 1) tick();
        chk("still_pend_at_last", wait_int, 1'b1);
        cmd(8'h01);
        chk("race_rel_entered", wait_end, 1'b1);
        chk("race_no_tmo_err", tmo_err, 1'b0);
        sb_push("race_pulse", END_LEN);
        wait_pulse();
        repeat (3) tick();

        // Clear coincident with timeout: set wins
        waits = 7'h08;
        sb_push("pend_status_88", 8'h88);
        wait_for_int();
        repeat (int'(TMO) - 1) tick();
        cmd(8'h02);
        chk("set_beats_clear", tmo_err, 1'b1);
        sb_push("set_clear_pulse", END_LEN);
        wait_pulse();
        repeat (3) tick();

        // Combined wait
        waits = 7'h01;
        sb_push("pend_status_81b", 8'h81);
        wait_for_int();
        waits = 7'h03;
        repeat (3) tick();
        chk("merged_status_83", status, 8'h83);
        sb_push("merged_pulse", END_LEN);
        cmd(8'h01);
        wait_pulse();
        repeat (3) tick();
        chk("merged_idle_status", status, 8'h03);
        no_pulse("merged_single", 20);

        // Stuck wait -> guard retry
        stuck = 1'b1;
        waits = 7'h01;
        sb_push("pend_status_81c", 8'h81);
        wait_for_int();
        sb_push("stuck_pulse1", END_LEN);
        cmd(8'h01);
        wait_pulse();
        n = 0;
        while (!wait_end && n < 50) begin
            n++;
            tick();
        end
        chk("guard_gap", n, 8);
        sb_push("stuck_pulse2", END_LEN);
        wait_pulse();
        n = 0;
        while (!wait_end && n < 50) begin
            n++;
            tick();
        end
        chk("guard_gap2", n, 8);
        sb_push("stuck_pulse3", END_LEN);
        wait_pulse();
        stuck = 1'b0;
        waits = 7'd0;
        repeat (4) tick();
        chk("guard_to_idle", wait_int, 1'b0);
        no_pulse("guard_idle_quiet", 20);

        // Reset mid-pulse
        waits = 7'h01;
        sb_push("pend_status_81d", 8'h81);
        wait_for_int();
        cmd(8'h01);
        tick();
        chk("second_pulse_cycle", wait_end, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_wait_end", wait_end, 1'b0);
        chk("async_rst_status", status, 8'h00);
        chk("async_rst_wait_int", wait_int, 1'b0);
        chk("async_rst_tmo_err", tmo_err, 1'b0);
        waits = 7'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        cmd(8'h01);
        no_pulse("idle_rel_ignored", 10);
        chk("idle_after_rst", wait_int, 1'b0);

        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
